// File: rtl/sample_fetch_trainer.sv
// sample_fetch_trainer: single-perceptron trainer that streams samples from a registered-read dataset RAM.
// Define PERCEPTRON_SAT_EN to saturate weight/bias updates to [-128,127] instead of wrapping modulo 256.
module sample_fetch_trainer #(
  parameter int SAMPLE_WIDTH = 18,
  parameter int ADDR_WIDTH   = 6,
  parameter int MAX_EPOCHS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [7:0]              w1,
  output logic [7:0]              w2,
  output logic [7:0]              bias,
  output logic [7:0]              epoch,
  output logic [ADDR_WIDTH:0]     err_count
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, UPDATE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = '1;
  localparam logic [7:0]            LAST_EPOCH = 8'(MAX_EPOCHS - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [7:0]              w1_reg, w1_next;
  logic [7:0]              w2_reg, w2_next;
  logic [7:0]              bias_reg, bias_next;
  logic [7:0]              epoch_reg, epoch_next;
  logic [ADDR_WIDTH:0]     err_cnt_reg, err_cnt_next, err_cnt_upd;
  logic                    conv_reg, conv_next;
  logic [7:0]              x_reg, x_next;
  logic [7:0]              y_reg, y_next;
  logic                    label_reg, label_next;
  logic signed [17:0]      sum_reg, sum_next;

  logic [7:0]              x_in, y_in;
  logic                    label_in;
  logic signed [17:0]      w1_ext, w2_ext, bias_ext, x_ext, y_ext, sum_calc;
  logic                    pred, mispredict;

  assign x_in     = data_in[SAMPLE_WIDTH-1 -: 8];
  assign y_in     = data_in[SAMPLE_WIDTH-9 -: 8];
  assign label_in = data_in[SAMPLE_WIDTH-17];

  generate
    if (SAMPLE_WIDTH > 17) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^data_in[SAMPLE_WIDTH-18:0];
    end
  endgenerate

  // Q4.4 x Q4.4 products land in Q8.8; bias is aligned by shifting its fraction up 4 bits.
  assign w1_ext   = {{10{w1_reg[7]}}, w1_reg};
  assign w2_ext   = {{10{w2_reg[7]}}, w2_reg};
  assign bias_ext = {{10{bias_reg[7]}}, bias_reg};
  assign x_ext    = {{10{x_in[7]}}, x_in};
  assign y_ext    = {{10{y_in[7]}}, y_in};
  assign sum_calc = w1_ext * x_ext + w2_ext * y_ext + (bias_ext <<< 4);

  assign pred        = (sum_reg >= 18'sd0);
  assign mispredict  = label_reg ^ pred;
  assign err_cnt_upd = err_cnt_reg + {{ADDR_WIDTH{1'b0}}, mispredict};

  // A misprediction with pred=1 means label 0, i.e. err = -1, so the sample is subtracted.
  function automatic logic [7:0] step(input logic [7:0] w, input logic [7:0] d, input logic neg);
    logic signed [8:0] s;
    s = neg ? ($signed({w[7], w}) - $signed({d[7], d}))
            : ($signed({w[7], w}) + $signed({d[7], d}));
`ifdef PERCEPTRON_SAT_EN
    if (s > 9'sd127)       step = 8'h7f;
    else if (s < -9'sd128) step = 8'h80;
    else                   step = s[7:0];
`else
    step = s[7:0];
`endif
  endfunction

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    addr_next    = addr_reg;
    w1_next      = w1_reg;
    w2_next      = w2_reg;
    bias_next    = bias_reg;
    epoch_next   = epoch_reg;
    err_cnt_next = err_cnt_reg;
    conv_next    = conv_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    label_next   = label_reg;
    sum_next     = sum_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          w1_next      = '0;
          w2_next      = '0;
          bias_next    = '0;
          epoch_next   = '0;
          err_cnt_next = '0;
          idx_next     = '0;
          addr_next    = '0;
          conv_next    = 1'b0;
          state_next   = FETCH;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = CALC;
      CALC: begin
        x_next     = x_in;
        y_next     = y_in;
        label_next = label_in;
        sum_next   = sum_calc;
        state_next = UPDATE;
      end
      UPDATE: begin
        if (mispredict) begin
          w1_next   = step(w1_reg, x_reg, pred);
          w2_next   = step(w2_reg, y_reg, pred);
          bias_next = step(bias_reg, 8'h10, pred);
        end
        err_cnt_next = err_cnt_upd;
        // addr_a is loaded on entry to FETCH so it is valid throughout the fetch.
        if (idx_reg != LAST_IDX) begin
          idx_next   = idx_reg + 1'b1;
          addr_next  = idx_reg + 1'b1;
          state_next = FETCH;
        end else if (err_cnt_upd == '0) begin
          conv_next  = 1'b1;
          state_next = DONE;
        end else if (epoch_reg == LAST_EPOCH) begin
          conv_next  = 1'b0;
          state_next = DONE;
        end else begin
          epoch_next   = epoch_reg + 8'd1;
          err_cnt_next = '0;
          idx_next     = '0;
          addr_next    = '0;
          state_next   = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      addr_reg    <= '0;
      w1_reg      <= '0;
      w2_reg      <= '0;
      bias_reg    <= '0;
      epoch_reg   <= '0;
      err_cnt_reg <= '0;
      conv_reg    <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      label_reg   <= 1'b0;
      sum_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      addr_reg    <= addr_next;
      w1_reg      <= w1_next;
      w2_reg      <= w2_next;
      bias_reg    <= bias_next;
      epoch_reg   <= epoch_next;
      err_cnt_reg <= err_cnt_next;
      conv_reg    <= conv_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      label_reg   <= label_next;
      sum_reg     <= sum_next;
    end
  end

  assign busy      = (state_reg == FETCH) || (state_reg == WAIT) ||
                     (state_reg == CALC)  || (state_reg == UPDATE);
  assign done      = (state_reg == DONE);
  assign converged = conv_reg;
  assign addr_a    = addr_reg;
  assign w1        = w1_reg;
  assign w2        = w2_reg;
  assign bias      = bias_reg;
  assign epoch     = epoch_reg;
  assign err_count = err_cnt_reg;

endmodule

// File: tb/tb_sample_fetch_trainer.sv
// Bench for sample_fetch_trainer: directed and random datasets checked against a behavioural perceptron model.
module tb_sample_fetch_trainer;
  localparam int NS = 64;
  localparam int ME = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  addr_a;
  logic [17:0] data_in;
  logic        busy, done, converged;
  logic [7:0]  w1, w2, bias, epoch;
  logic [6:0]  err_count;

  logic [17:0] mem [NS];
  int n_cmp = 0;
  int n_bad = 0;
  int m_w1, m_w2, m_b, m_epoch, m_err, m_conv, m_cycles;
  int f_w1, f_w2, f_b, f_err;
  int d_w1, d_w2, d_b, d_err, last_cyc;

  sample_fetch_trainer dut (
    .clk(clk), .rst(rst), .start(start), .addr_a(addr_a), .data_in(data_in),
    .busy(busy), .done(done), .converged(converged),
    .w1(w1), .w2(w2), .bias(bias), .epoch(epoch), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) data_in <= mem[addr_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int fit8(input int v);
`ifdef PERCEPTRON_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    int r;
    r = ((v % 256) + 256) % 256;
    return (r > 127) ? r - 256 : r;
`endif
  endfunction

  function automatic int sx(input int i);
    logic [7:0] b;
    b = mem[i][17:10];
    return int'($signed(b));
  endfunction
  function automatic int sy(input int i);
    logic [7:0] b;
    b = mem[i][9:2];
    return int'($signed(b));
  endfunction
  function automatic int lbl(input int i);
    return mem[i][1] ? 1 : 0;
  endfunction

  // Textbook perceptron with learning rate 1 over the whole dataset, epoch by epoch.
  task automatic model_run();
    int wa, wb, bb, errs, sum, pred, e;
    wa = 0; wb = 0; bb = 0; errs = 0;
    m_cycles = 0; m_conv = 0; m_epoch = 0;
    for (int ep = 0; ep < ME; ep++) begin
      errs = 0;
      for (int i = 0; i < NS; i++) begin
        sum  = wa * sx(i) + wb * sy(i) + bb * 16;
        pred = (sum >= 0) ? 1 : 0;
        e    = lbl(i) - pred;
        if (e != 0) begin
          wa = fit8(wa + e * sx(i));
          wb = fit8(wb + e * sy(i));
          bb = fit8(bb + e * 16);
          errs++;
        end
        m_cycles += 4;
        if (ep == 0 && i == 0) begin
          f_w1 = wa; f_w2 = wb; f_b = bb; f_err = errs;
        end
      end
      m_epoch = ep;
      if (errs == 0) begin
        m_conv = 1;
        break;
      end
    end
    m_w1 = wa; m_w2 = wb; m_b = bb; m_err = errs;
  endtask

  task automatic check_final(input string name);
    chk({name, "_w1"}, 32'(w1), 32'(m_w1 & 255));
    chk({name, "_w2"}, 32'(w2), 32'(m_w2 & 255));
    chk({name, "_bias"}, 32'(bias), 32'(m_b & 255));
    chk({name, "_epoch"}, 32'(epoch), 32'(m_epoch));
    chk({name, "_errcnt"}, 32'(err_count), 32'(m_err));
    chk({name, "_conv"}, 32'(converged), 32'(m_conv));
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run_training(input string name, input int glitch_at);
    int cyc;
    bit finished;
    model_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; finished = 1'b0;
    chk({name, "_addr0"}, 32'(addr_a), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < 20000; k++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (busy) cyc++;
      if (k == 4) begin
        d_w1 = int'(w1); d_w2 = int'(w2); d_b = int'(bias); d_err = int'(err_count);
        chk({name, "_first_w1"}, 32'(w1), 32'(f_w1 & 255));
        chk({name, "_first_w2"}, 32'(w2), 32'(f_w2 & 255));
        chk({name, "_first_bias"}, 32'(bias), 32'(f_b & 255));
        chk({name, "_first_err"}, 32'(err_count), 32'(f_err));
        chk({name, "_first_addr"}, 32'(addr_a), 32'd1);
      end
      start = (k == glitch_at);
      @(negedge clk);
    end
    start = 1'b0;
    last_cyc = cyc;
    chk({name, "_finished"}, 32'(finished), 32'd1);
    chk({name, "_cycles"}, 32'(cyc), 32'(m_cycles));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    check_final(name);
    repeat (3) @(negedge clk);
    check_final({name, "_held"});
    $display("run %s: cycles=%0d epoch=%0d conv=%0d w1=%0h w2=%0h bias=%0h", name, cyc,
             epoch, converged, w1, w2, bias);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_addr"}, 32'(addr_a), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_conv"}, 32'(converged), 32'd0);
    chk({name, "_w1"}, 32'(w1), 32'd0);
    chk({name, "_w2"}, 32'(w2), 32'd0);
    chk({name, "_bias"}, 32'(bias), 32'd0);
    chk({name, "_epoch"}, 32'(epoch), 32'd0);
    chk({name, "_errcnt"}, 32'(err_count), 32'd0);
  endtask

  task automatic load_standard();
    int k, dx, dy;
    for (int i = 0; i < NS; i++) begin
      k = i / 2; dx = (k % 4) * 4; dy = ((k / 4) % 4) * 4;
      if (i % 2 == 0) mem[i] = {8'(-16 - dx), 8'(-16 - dy), 1'b0, 1'b0};
      else            mem[i] = {8'(16 + dx), 8'(16 + dy), 1'b1, 1'b0};
    end
  endtask

  initial begin
    int bad, sum, xs, ys;
    for (int i = 0; i < NS; i++) mem[i] = '0;
    #3 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Standard separable dataset; start pulsed mid-run must be ignored.
    load_standard();
    run_training("std", 9);
    chk("std_first_w1_const", 32'(d_w1), 32'h10);
    chk("std_first_w2_const", 32'(d_w2), 32'h10);
    chk("std_first_bias_const", 32'(d_b), 32'hf0);
    chk("std_first_err_const", 32'(d_err), 32'd1);
    chk("std_conv_const", 32'(converged), 32'd1);
    chk("std_within_bound", 32'(last_cyc < 16 * 64 * 4 + 4), 32'd1);
    bad = 0;
    for (int i = 0; i < NS; i++) begin
      sum = int'($signed(w1)) * sx(i) + int'($signed(w2)) * sy(i) + int'($signed(bias)) * 16;
      if (((sum >= 0) ? 1 : 0) != lbl(i)) bad++;
    end
    chk("std_pred_all", 32'(bad), 32'd0);

    // Reset asserted during CALC of sample 5.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    chk("midcalc_addr", 32'(addr_a), 32'd5);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midcalc_rst");
    @(negedge clk); rst = 1'b0;
    run_training("post_rst", -1);

    // Extreme samples exercise saturation vs wrap.
    for (int i = 0; i < NS; i++) mem[i] = {8'h80, 8'h80, 1'b0, 1'b0};
`ifdef PERCEPTRON_SAT_EN
    run_training("sat", 50);
    chk("sat_first_w1_const", 32'(d_w1), 32'h7f);
    chk("sat_first_w2_const", 32'(d_w2), 32'h7f);
`else
    run_training("wrap", 50);
    chk("wrap_first_w1_const", 32'(d_w1), 32'h80);
    chk("wrap_first_w2_const", 32'(d_w2), 32'h80);
`endif

    // Contradictory labels on one point never converge.
    for (int i = 0; i < NS; i++) mem[i] = {8'h10, 8'h10, 1'(i % 2), 1'b0};
    run_training("contra", 100);
    chk("contra_conv_const", 32'(converged), 32'd0);
    chk("contra_epoch_const", 32'(epoch), 32'd15);
    chk("contra_cycles_const", 32'(last_cyc), 32'(16 * 64 * 4));

    // Random datasets: linear rule labels and pure noise labels.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        mem[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0};
        xs = sx(i); ys = sy(i);
        if (r < 2) mem[i][1] = (3 * xs - 2 * ys + 40 > 0);
        else       mem[i][1] = 1'($urandom_range(0, 1));
      end
      run_training($sformatf("rnd%0d", r), int'($urandom_range(5, 200)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
